// File: rtl/pi_ctrl_param.sv
// pi_ctrl_param: incremental PI voltage-loop controller turning an ADC sample into a clamped divider count.
// Defining PI_DERIV_EN adds a kd_shift port, e2 history and a derivative term (latency unchanged).
module pi_ctrl_param #(
    parameter int DW       = 13,
    parameter int OW       = 12,
    parameter int SP_INIT  = 3430,
    parameter int SP_MIN   = 0,
    parameter int SP_MAX   = 4000,
    parameter int SP_STEP  = 5,
    parameter int OUT_INIT = 520,
    parameter int OUT_MIN  = 416,
    parameter int OUT_MAX  = 625
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sample_en,
    input  logic signed [DW-1:0] meas,
    input  logic                 key_add,
    input  logic                 key_sub,
    input  logic [3:0]           kp_shift,
    input  logic [3:0]           ki_shift,
`ifdef PI_DERIV_EN
    input  logic [3:0]           kd_shift,
`endif
    input  logic                 hold,
    output logic signed [DW-1:0] setpoint,
    output logic [OW-1:0]        out_cnt,
    output logic                 out_valid,
    output logic                 sat_hi,
    output logic                 sat_lo,
    output logic                 busy,
    output logic                 overrun
);

    localparam int AW = OW + 3;
    localparam logic signed [DW:0]   E_MAX    = (DW+1)'(2**(DW-1) - 1);
    localparam logic signed [DW:0]   E_MIN    = (DW+1)'(-(2**(DW-1)));
    localparam logic signed [DW:0]   SP_HI    = (DW+1)'(SP_MAX);
    localparam logic signed [DW:0]   SP_LO    = (DW+1)'(SP_MIN);
    localparam logic signed [DW:0]   SP_INC   = (DW+1)'(SP_STEP);
    localparam logic signed [DW-1:0] SP_RST   = DW'(SP_INIT);
    localparam logic signed [AW-1:0] ACC_HI   = AW'(OUT_MAX);
    localparam logic signed [AW-1:0] ACC_LO   = AW'(OUT_MIN);
    localparam logic [OW-1:0]        CNT_MAX  = OW'(OUT_MAX);
    localparam logic [OW-1:0]        CNT_MIN  = OW'(OUT_MIN);
    localparam logic [OW-1:0]        CNT_INIT = OW'(OUT_INIT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ERR  = 3'd1,
        S_TERM = 3'd2,
        S_SUM  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    function automatic logic signed [DW-1:0] sat_err(input logic signed [DW:0] v);
        logic signed [DW-1:0] r;
        if (v > E_MAX) begin
            r = E_MAX[DW-1:0];
        end else if (v < E_MIN) begin
            r = E_MIN[DW-1:0];
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

    // The clamped value, not acc, feeds the next increment: this is the anti-windup.
    function automatic logic [OW-1:0] clamp_cnt(input logic signed [AW-1:0] a);
        logic [OW-1:0] r;
        if (a >= ACC_HI) begin
            r = CNT_MAX;
        end else if (a <= ACC_LO) begin
            r = CNT_MIN;
        end else begin
            r = a[OW-1:0];
        end
        return r;
    endfunction

    state_t state_q, state_d;
    logic signed [DW-1:0] meas_q, meas_d, e_q, e_d, e1_q, e1_d, ti_q, ti_d;
    logic signed [DW:0]   tp_q, tp_d, tp_full_s, err_full_s, sp_up_s, sp_dn_s;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] setpoint_q, setpoint_d;
    logic [OW-1:0]        out_cnt_q, out_cnt_d;
    logic                 out_valid_q, sat_hi_q, sat_lo_q, overrun_q, overrun_d;
    logic [1:0]           kadd_q, ksub_q;
    logic                 add_rise_s, sub_rise_s, busy_s, start_s;
    logic                 ld_meas_s, ld_err_s, ld_term_s, ld_sum_s, ld_out_s;
`ifdef PI_DERIV_EN
    logic signed [DW-1:0] e2_q, e2_d;
    logic signed [DW+1:0] td_q, td_d, td_full_s;
`endif

    assign busy_s     = (state_q != S_IDLE);
    assign start_s    = sample_en & ~hold;
    assign add_rise_s = kadd_q[0] & ~kadd_q[1];
    assign sub_rise_s = ksub_q[0] & ~ksub_q[1];

    // FSM next-state logic: one cycle per state once an update starts.
    always_comb begin
        case (state_q)
            S_IDLE:  state_d = start_s ? S_ERR : S_IDLE;
            S_ERR:   state_d = S_TERM;
            S_TERM:  state_d = S_SUM;
            S_SUM:   state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode: per-state load enables for the datapath.
    always_comb begin
        ld_meas_s = 1'b0;
        ld_err_s  = 1'b0;
        ld_term_s = 1'b0;
        ld_sum_s  = 1'b0;
        ld_out_s  = 1'b0;
        case (state_q)
            S_IDLE:  ld_meas_s = start_s;
            S_ERR:   ld_err_s  = 1'b1;
            S_TERM:  ld_term_s = 1'b1;
            S_SUM:   ld_sum_s  = 1'b1;
            S_OUT:   ld_out_s  = 1'b1;
            default: ld_meas_s = 1'b0;
        endcase
    end

    // Datapath next-state: error, shifted terms, accumulation and output clamp.
    always_comb begin
        err_full_s = {setpoint_q[DW-1], setpoint_q} - {meas_q[DW-1], meas_q};
        tp_full_s  = {e_q[DW-1], e_q} - {e1_q[DW-1], e1_q};
`ifdef PI_DERIV_EN
        td_full_s  = {{2{e_q[DW-1]}}, e_q} - {e1_q[DW-1], e1_q, 1'b0} + {{2{e2_q[DW-1]}}, e2_q};
`endif
        if (ld_meas_s) begin
            meas_d = meas;
        end else begin
            meas_d = meas_q;
        end
        if (ld_err_s) begin
            e_d = sat_err(err_full_s);
        end else begin
            e_d = e_q;
        end
        if (ld_term_s) begin
            ti_d = e_q >>> ki_shift;
            tp_d = tp_full_s >>> kp_shift;
`ifdef PI_DERIV_EN
            td_d = td_full_s >>> kd_shift;
`endif
        end else begin
            ti_d = ti_q;
            tp_d = tp_q;
`ifdef PI_DERIV_EN
            td_d = td_q;
`endif
        end
        if (ld_sum_s) begin
`ifdef PI_DERIV_EN
            acc_d = $signed({3'b000, out_cnt_q}) + AW'(ti_q) + AW'(tp_q) + AW'(td_q);
`else
            acc_d = $signed({3'b000, out_cnt_q}) + AW'(ti_q) + AW'(tp_q);
`endif
        end else begin
            acc_d = acc_q;
        end
        if (ld_out_s) begin
            out_cnt_d = clamp_cnt(acc_q);
            e1_d      = e_q;
`ifdef PI_DERIV_EN
            e2_d      = e1_q;
`endif
        end else begin
            out_cnt_d = out_cnt_q;
            e1_d      = e1_q;
`ifdef PI_DERIV_EN
            e2_d      = e2_q;
`endif
        end
        overrun_d = overrun_q | (start_s & busy_s);
    end

    // Setpoint next-state: saturate before writing so it never leaves [SP_MIN, SP_MAX].
    always_comb begin
        sp_up_s = {setpoint_q[DW-1], setpoint_q} + SP_INC;
        sp_dn_s = {setpoint_q[DW-1], setpoint_q} - SP_INC;
        case ({add_rise_s, sub_rise_s})
            2'b10:   setpoint_d = (sp_up_s > SP_HI) ? SP_HI[DW-1:0] : sp_up_s[DW-1:0];
            2'b01:   setpoint_d = (sp_dn_s < SP_LO) ? SP_LO[DW-1:0] : sp_dn_s[DW-1:0];
            default: setpoint_d = setpoint_q;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            meas_q      <= '0;
            e_q         <= '0;
            e1_q        <= '0;
            ti_q        <= '0;
            tp_q        <= '0;
            acc_q       <= '0;
            out_cnt_q   <= CNT_INIT;
            out_valid_q <= 1'b0;
            sat_hi_q    <= (CNT_INIT == CNT_MAX);
            sat_lo_q    <= (CNT_INIT == CNT_MIN);
            overrun_q   <= 1'b0;
            setpoint_q  <= SP_RST;
            kadd_q      <= 2'b00;
            ksub_q      <= 2'b00;
`ifdef PI_DERIV_EN
            e2_q        <= '0;
            td_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            meas_q      <= meas_d;
            e_q         <= e_d;
            e1_q        <= e1_d;
            ti_q        <= ti_d;
            tp_q        <= tp_d;
            acc_q       <= acc_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= ld_out_s;
            sat_hi_q    <= (out_cnt_d == CNT_MAX);
            sat_lo_q    <= (out_cnt_d == CNT_MIN);
            overrun_q   <= overrun_d;
            setpoint_q  <= setpoint_d;
            kadd_q      <= {kadd_q[0], key_add};
            ksub_q      <= {ksub_q[0], key_sub};
`ifdef PI_DERIV_EN
            e2_q        <= e2_d;
            td_q        <= td_d;
`endif
        end
    end

    assign setpoint  = setpoint_q;
    assign out_cnt   = out_cnt_q;
    assign out_valid = out_valid_q;
    assign sat_hi    = sat_hi_q;
    assign sat_lo    = sat_lo_q;
    assign busy      = busy_s;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pi_ctrl_param.sv
// Table-driven bench for pi_ctrl_param: hand-computed update vectors plus key, protocol and reset sequences.
module tb_pi_ctrl_param;

    logic               clk = 1'b0;
    logic               rstn, sample_en, key_add, key_sub, hold;
    logic signed [12:0] meas;
    logic [3:0]         kp_shift, ki_shift;
`ifdef PI_DERIV_EN
    logic [3:0]         kd_shift;
`endif
    logic signed [12:0] setpoint;
    logic [11:0]        out_cnt;
    logic               out_valid, sat_hi, sat_lo, busy, overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    pi_ctrl_param dut (
        .clk(clk), .rstn(rstn), .sample_en(sample_en), .meas(meas),
        .key_add(key_add), .key_sub(key_sub), .kp_shift(kp_shift), .ki_shift(ki_shift),
`ifdef PI_DERIV_EN
        .kd_shift(kd_shift),
`endif
        .hold(hold), .setpoint(setpoint), .out_cnt(out_cnt), .out_valid(out_valid),
        .sat_hi(sat_hi), .sat_lo(sat_lo), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [12:0] meas;
        logic [3:0]         kp;
        logic [3:0]         ki;
        int                 exp_out;
        int                 exp_hi;
        int                 exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Strobe one sample at a negedge and return the number of negedges until out_valid (-1 on timeout).
    task automatic run_update(input logic signed [12:0] m, input logic [3:0] kp, input logic [3:0] ki,
                              output int lat);
        meas = m; kp_shift = kp; ki_shift = ki; sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int n, output int pulses, output int last_out);
        pulses = 0;
        last_out = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                last_out = int'(out_cnt);
            end
        end
    endtask

    task automatic press(input logic a, input logic s);
        key_add = a; key_sub = s;
        @(negedge clk);
        @(negedge clk);
        key_add = 1'b0; key_sub = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat, pulses, last;

        // Each vector continues from the out_cnt and e1 left by the previous one.
        vecs[0]  = '{13'sd3430, 4'd1,  4'd3,  520, 0, 0};
        vecs[1]  = '{13'sd3350, 4'd1,  4'd3,  570, 0, 0};
        vecs[2]  = '{13'sd3350, 4'd1,  4'd3,  580, 0, 0};
        vecs[3]  = '{13'sd0,    4'd1,  4'd3,  625, 1, 0};
        vecs[4]  = '{13'sd4095, 4'd1,  4'd3,  416, 0, 1};
        vecs[5]  = '{13'sd3430, 4'd1,  4'd3,  625, 1, 0};
        vecs[6]  = '{13'sd3430, 4'd0,  4'd0,  625, 1, 0};
        vecs[7]  = '{13'sd3530, 4'd2,  4'd4,  593, 0, 0};
        vecs[8]  = '{13'sd3530, 4'd2,  4'd4,  586, 0, 0};
        vecs[9]  = '{13'sd3400, 4'd15, 4'd15, 586, 0, 0};
        vecs[10] = '{13'h1000,  4'd1,  4'd3,  625, 1, 0};
        vecs[11] = '{13'sd4095, 4'd0,  4'd0,  416, 0, 1};

        sample_en = 1'b0; key_add = 1'b0; key_sub = 1'b0; hold = 1'b0;
        meas = '0; kp_shift = 4'd1; ki_shift = 4'd3;
`ifdef PI_DERIV_EN
        kd_shift = 4'd0;
`endif
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset out_cnt", int'(out_cnt), 520);
        check("reset setpoint", int'(setpoint), 3430);
        check("reset out_valid", int'(out_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset overrun", int'(overrun), 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_update(vecs[i].meas, vecs[i].kp, vecs[i].ki, lat);
            check($sformatf("vec%0d latency", i), lat, 4);
            check($sformatf("vec%0d out_cnt", i), int'(out_cnt), vecs[i].exp_out);
            check($sformatf("vec%0d sat_hi", i), int'(sat_hi), vecs[i].exp_hi);
            check($sformatf("vec%0d sat_lo", i), int'(sat_lo), vecs[i].exp_lo);
            @(negedge clk);
            check($sformatf("vec%0d valid pulse end", i), int'(out_valid), 0);
            check($sformatf("vec%0d busy end", i), int'(busy), 0);
        end
        check("table no overrun", int'(overrun), 0);

        for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
        check("key 3 adds", int'(setpoint), 3445);
        for (int i = 0; i < 111; i++) press(1'b1, 1'b0);
        check("key reach max", int'(setpoint), 4000);
        press(1'b1, 1'b0);
        check("key clamp max", int'(setpoint), 4000);
        press(1'b1, 1'b1);
        check("key both edges", int'(setpoint), 4000);
        press(1'b0, 1'b1);
        check("key one sub", int'(setpoint), 3995);
        for (int i = 0; i < 799; i++) press(1'b0, 1'b1);
        check("key reach min", int'(setpoint), 0);
        press(1'b0, 1'b1);
        check("key clamp min", int'(setpoint), 0);

        do_reset();
        check("sp after reset", int'(setpoint), 3430);
        hold = 1'b1; meas = 13'sd0; sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        count_pulses(8, pulses, last);
        check("hold no update", pulses, 0);
        check("hold out_cnt", int'(out_cnt), 520);
        check("hold no overrun", int'(overrun), 0);
        hold = 1'b0;

        meas = 13'sd3350; kp_shift = 4'd1; ki_shift = 4'd3; sample_en = 1'b1;
        @(negedge clk);
        meas = 13'sd0;
        @(negedge clk);
        @(negedge clk);
        sample_en = 1'b0;
        count_pulses(10, pulses, last);
        check("overrun single pulse", pulses, 1);
        check("overrun out_cnt", last, 570);
        check("overrun sticky", int'(overrun), 1);

        meas = 13'sd0; sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("abort busy", int'(busy), 0);
        check("abort out_cnt", int'(out_cnt), 520);
        check("abort overrun", int'(overrun), 0);
        count_pulses(8, pulses, last);
        check("abort no pulse", pulses, 0);
        run_update(13'sd3350, 4'd1, 4'd3, lat);
        check("post-abort latency", lat, 4);
        check("post-abort out_cnt", int'(out_cnt), 570);

`ifdef PI_DERIV_EN
        do_reset();
        kd_shift = 4'd0;
        run_update(13'sd3430, 4'd15, 4'd15, lat);
        check("deriv e=0", int'(out_cnt), 520);
        run_update(13'sd3350, 4'd15, 4'd15, lat);
        check("deriv td=+80", int'(out_cnt), 600);
        run_update(13'sd3350, 4'd15, 4'd15, lat);
        check("deriv td=-80", int'(out_cnt), 520);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
